// File: rtl/assert_time_stim_pkg.sv
// Shared constants and FSM state type for the time-window stimulus generator.
package assert_time_stim_pkg;
  localparam int OVL_IGNORE_NEW_START   = 0;
  localparam int OVL_RESET_ON_NEW_START = 1;
  localparam int OVL_ERROR_ON_NEW_START = 2;
  localparam int COV_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WINDOW = 2'd2
  } state_t;
endpackage

// File: rtl/assert_time_win_cnt.sv
// Loadable window down-counter; flags the last window cycle now and next cycle.
module assert_time_win_cnt #(
  parameter int NUM_CKS = 2,
  parameter int CNT_W   = $clog2(NUM_CKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last,
  output logic last_nxt
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (load)
      cnt_d = CNT_W'(NUM_CKS);
    else if (dec && cnt != '0)
      cnt_d = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_d;
  end

  assign last     = (cnt == CNT_W'(1));
  assign last_nxt = (cnt_d == CNT_W'(1));
endmodule

// File: rtl/assert_time_stim_gen.sv
// Stimulus generator for the time-window checker; all outputs registered.
// Optional coverage counters enabled by ASSERT_TIME_STIM_GEN_COVER_EN.
module assert_time_stim_gen
  import assert_time_stim_pkg::*;
#(
  parameter int NUM_CKS             = 2,
  parameter int ACTION_ON_NEW_START = 0,
  parameter int CNT_W               = $clog2(NUM_CKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             inject_err,
  output logic             start_event,
  output logic             test_expr,
  output logic             window,
  output logic             window_close,
  output logic             busy,
  output logic             ignored_start,
  output logic             new_start_err,
  output logic [COV_W-1:0] cov_windows,
  output logic [COV_W-1:0] cov_restarts
);
  state_t state, state_nxt;
  logic   err_flag;
  logic   last, last_nxt;
  logic   new_start, accept, restart_nxt;
  logic   se_nxt, te_nxt, win_nxt, wc_nxt, busy_nxt, ig_nxt, nse_nxt;

  assert_time_win_cnt #(.NUM_CKS(NUM_CKS), .CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == START),
    .dec      (state == WINDOW),
    .last     (last),
    .last_nxt (last_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) err_flag <= inject_err;
    end
  end

  // A req on the closing cycle is a plain back-to-back start, never a new start.
  always_comb begin
    new_start   = req && (state == START || (state == WINDOW && !last));
    restart_nxt = new_start && (ACTION_ON_NEW_START == OVL_RESET_ON_NEW_START);
    accept      = req && (state == IDLE || (state == WINDOW && last) || restart_nxt);
    state_nxt   = state;
    case (state)
      IDLE:    if (req) state_nxt = START;
      START:   state_nxt = restart_nxt ? START : WINDOW;
      WINDOW:  if (last) state_nxt = req ? START : IDLE;
               else if (restart_nxt) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    se_nxt   = (state_nxt == START);
    win_nxt  = (state_nxt == WINDOW) || (se_nxt && restart_nxt);
    wc_nxt   = (state_nxt == WINDOW) && last_nxt;
    te_nxt   = ((state_nxt == WINDOW) && !(err_flag && last_nxt)) || (se_nxt && restart_nxt);
    busy_nxt = (state_nxt != IDLE);
    ig_nxt   = new_start && (ACTION_ON_NEW_START == OVL_IGNORE_NEW_START);
    nse_nxt  = new_start && (ACTION_ON_NEW_START == OVL_ERROR_ON_NEW_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_event   <= 1'b0;
      test_expr     <= 1'b0;
      window        <= 1'b0;
      window_close  <= 1'b0;
      busy          <= 1'b0;
      ignored_start <= 1'b0;
      new_start_err <= 1'b0;
    end else begin
      start_event   <= se_nxt;
      test_expr     <= te_nxt;
      window        <= win_nxt;
      window_close  <= wc_nxt;
      busy          <= busy_nxt;
      ignored_start <= ig_nxt;
      new_start_err <= nse_nxt;
    end
  end

`ifdef ASSERT_TIME_STIM_GEN_COVER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_windows  <= '0;
      cov_restarts <= '0;
    end else begin
      if (wc_nxt && cov_windows != '1)       cov_windows  <= cov_windows + COV_W'(1);
      if (restart_nxt && cov_restarts != '1) cov_restarts <= cov_restarts + COV_W'(1);
    end
  end
`else
  assign cov_windows  = '0;
  assign cov_restarts = '0;
`endif
endmodule

// File: tb/tb_assert_time_stim_gen.sv
// Directed table-driven bench: five generator configurations share one stimulus bus.
module tb_assert_time_stim_gen;
  logic clk = 1'b0;
  logic rst = 1'b1, req = 1'b0, inj = 1'b0;
  logic [4:0] se, te, w, wc, bz, ig, ne;
  logic [15:0] cw [5];
  logic [15:0] cr [5];

  always #5 clk = ~clk;

  assert_time_stim_gen #(.NUM_CKS(3), .ACTION_ON_NEW_START(0)) u0 (.clk(clk), .reset(rst), .req(req), .inject_err(inj),
    .start_event(se[0]), .test_expr(te[0]), .window(w[0]), .window_close(wc[0]), .busy(bz[0]),
    .ignored_start(ig[0]), .new_start_err(ne[0]), .cov_windows(cw[0]), .cov_restarts(cr[0]));
  assert_time_stim_gen #(.NUM_CKS(4), .ACTION_ON_NEW_START(0)) u1 (.clk(clk), .reset(rst), .req(req), .inject_err(inj),
    .start_event(se[1]), .test_expr(te[1]), .window(w[1]), .window_close(wc[1]), .busy(bz[1]),
    .ignored_start(ig[1]), .new_start_err(ne[1]), .cov_windows(cw[1]), .cov_restarts(cr[1]));
  assert_time_stim_gen #(.NUM_CKS(4), .ACTION_ON_NEW_START(1)) u2 (.clk(clk), .reset(rst), .req(req), .inject_err(inj),
    .start_event(se[2]), .test_expr(te[2]), .window(w[2]), .window_close(wc[2]), .busy(bz[2]),
    .ignored_start(ig[2]), .new_start_err(ne[2]), .cov_windows(cw[2]), .cov_restarts(cr[2]));
  assert_time_stim_gen #(.NUM_CKS(4), .ACTION_ON_NEW_START(2)) u3 (.clk(clk), .reset(rst), .req(req), .inject_err(inj),
    .start_event(se[3]), .test_expr(te[3]), .window(w[3]), .window_close(wc[3]), .busy(bz[3]),
    .ignored_start(ig[3]), .new_start_err(ne[3]), .cov_windows(cw[3]), .cov_restarts(cr[3]));
  assert_time_stim_gen #(.NUM_CKS(2), .ACTION_ON_NEW_START(0)) u4 (.clk(clk), .reset(rst), .req(req), .inject_err(inj),
    .start_event(se[4]), .test_expr(te[4]), .window(w[4]), .window_close(wc[4]), .busy(bz[4]),
    .ignored_start(ig[4]), .new_start_err(ne[4]), .cov_windows(cw[4]), .cov_restarts(cr[4]));

  typedef struct { int scn; int cyc; logic req; logic inj; logic rst; } stim_t;
  // exp bit order: start_event, test_expr, window, window_close, busy, ignored_start, new_start_err
  typedef struct { int scn; int cyc; logic [6:0] exp; logic chk_cov; int cwx; int crx; } chk_t;

  stim_t st[$];
  chk_t  ck[$];
  int    scn_dut [7] = '{0, 0, 1, 2, 3, 4, 0};
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input int d, input chk_t c);
    logic [6:0] got;
    logic [15:0] want_w, want_r;
    got = {se[d], te[d], w[d], wc[d], bz[d], ig[d], ne[d]};
    vectors++;
    if (got !== c.exp) begin
      miscompares++;
      $display("FAIL outputs scn%0d cyc%0d dut%0d: got %b want %b", c.scn, c.cyc, d, got, c.exp);
    end
    if (c.chk_cov) begin
`ifdef ASSERT_TIME_STIM_GEN_COVER_EN
      want_w = 16'(c.cwx);
      want_r = 16'(c.crx);
`else
      want_w = 16'd0;
      want_r = 16'd0;
`endif
      vectors++;
      if (cw[d] !== want_w || cr[d] !== want_r) begin
        miscompares++;
        $display("FAIL coverage scn%0d cyc%0d dut%0d: got win=%0d rst=%0d want win=%0d rst=%0d",
                 c.scn, c.cyc, d, cw[d], cr[d], want_w, want_r);
      end
    end
  endtask

  initial begin
    // scn0: single window, NUM_CKS=3
    st.push_back('{0, 10, 1'b1, 1'b0, 1'b0});
    ck.push_back('{0,  2, 7'b0000000, 1'b1, 0, 0});
    ck.push_back('{0, 10, 7'b0000000, 1'b0, 0, 0});
    ck.push_back('{0, 11, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{0, 12, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{0, 13, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{0, 14, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{0, 15, 7'b0000000, 1'b1, 1, 0});
    // scn1: injected error drops test_expr on the last cycle only
    st.push_back('{1, 10, 1'b1, 1'b1, 1'b0});
    ck.push_back('{1, 12, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{1, 13, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{1, 14, 7'b0011100, 1'b0, 0, 0});
    ck.push_back('{1, 15, 7'b0000000, 1'b0, 0, 0});
    // scn2: policy 0; stray inject_err and dropped req must not corrupt the window
    st.push_back('{2,  5, 1'b0, 1'b1, 1'b0});
    st.push_back('{2, 10, 1'b1, 1'b0, 1'b0});
    st.push_back('{2, 13, 1'b1, 1'b1, 1'b0});
    ck.push_back('{2, 11, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{2, 13, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{2, 14, 7'b0110110, 1'b0, 0, 0});
    ck.push_back('{2, 15, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{2, 16, 7'b0000000, 1'b0, 0, 0});
    // scn3: policy 1 restart extends the window
    st.push_back('{3, 10, 1'b1, 1'b0, 1'b0});
    st.push_back('{3, 13, 1'b1, 1'b0, 1'b0});
    ck.push_back('{3, 11, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{3, 13, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{3, 14, 7'b1110100, 1'b0, 0, 0});
    ck.push_back('{3, 15, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{3, 17, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{3, 18, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{3, 19, 7'b0000000, 1'b1, 1, 1});
    // scn4: policy 2 flags the new start
    st.push_back('{4, 10, 1'b1, 1'b0, 1'b0});
    st.push_back('{4, 13, 1'b1, 1'b0, 1'b0});
    ck.push_back('{4, 14, 7'b0110101, 1'b0, 0, 0});
    ck.push_back('{4, 15, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{4, 16, 7'b0000000, 1'b1, 1, 0});
    // scn5: back-to-back, NUM_CKS=2
    st.push_back('{5, 10, 1'b1, 1'b0, 1'b0});
    st.push_back('{5, 13, 1'b1, 1'b0, 1'b0});
    ck.push_back('{5, 11, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{5, 12, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{5, 13, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{5, 14, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{5, 15, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{5, 16, 7'b0111100, 1'b0, 0, 0});
    ck.push_back('{5, 17, 7'b0000000, 1'b1, 2, 0});
    // scn6: req during reset dropped; mid-window reset aborts without close
    st.push_back('{6,  1, 1'b1, 1'b0, 1'b0});
    st.push_back('{6, 10, 1'b1, 1'b0, 1'b0});
    st.push_back('{6, 13, 1'b0, 1'b0, 1'b1});
    st.push_back('{6, 20, 1'b1, 1'b0, 1'b0});
    ck.push_back('{6,  2, 7'b0000000, 1'b0, 0, 0});
    ck.push_back('{6,  3, 7'b0000000, 1'b0, 0, 0});
    ck.push_back('{6, 13, 7'b0110100, 1'b0, 0, 0});
    ck.push_back('{6, 14, 7'b0000000, 1'b0, 0, 0});
    ck.push_back('{6, 15, 7'b0000000, 1'b0, 0, 0});
    ck.push_back('{6, 16, 7'b0000000, 1'b1, 0, 0});
    ck.push_back('{6, 21, 7'b1000100, 1'b0, 0, 0});
    ck.push_back('{6, 22, 7'b0110100, 1'b0, 0, 0});

    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 24; c++) begin
        @(posedge clk);
        #1;
        foreach (ck[k])
          if (ck[k].scn == s && ck[k].cyc == c) check(scn_dut[s], ck[k]);
        rst = (c < 2);
        req = 1'b0;
        inj = 1'b0;
        foreach (st[k])
          if (st[k].scn == s && st[k].cyc == c) begin
            req = st[k].req;
            inj = st[k].inj;
            rst = rst | st[k].rst;
          end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
